mem_arbiter: RTL and testbench

- Two-requester arbiter that shares the single-port 512x16 synchronous data/instruction RAM between the CPU (fetch, load, store) and a loader/debug port that pre-loads and inspects memory.
- Sits between the cpu block's mem_cmd/mem_addr outputs and the RAM.
- Sequences each access as a fixed 3-cycle transaction with a registered grant and a one-cycle acknowledge.
- Round-robin fairness when both requesters are active.

---
 rtl/mem_pkg.sv | 32 +++
 rtl/mem_arbiter_rr_pick.sv | 27 ++
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mem_pkg
// Description : Shared definitions for the RAM access path. Holds the memory
//               command encoding (also used by the cpu state machine), the
//               arbiter state encoding, default bus widths and a helper that
//               decides whether a command is an active request.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Memory command encoding; 2'b11 is reserved and behaves like MNONE.
  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  // Only READ and WRITE count as requests, so the reserved code is never granted.
  function automatic logic cmd_active(input logic [1:0] cmd);
    return (cmd == MREAD) || (cmd == MWRITE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational two-way round-robin selector. A lone requester
//               always wins; when both request, the side named by i_prio
//               (1 = CPU, 0 = loader) wins.
// Ports       : i_req_cpu / i_req_ld - active requests
//               i_prio               - tie-break pointer (1 = CPU)
//               o_gnt_cpu / o_gnt_ld - one-hot grant (both 0 when idle)
//               o_any                - at least one request is active
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick (
  input  logic i_req_cpu,
  input  logic i_req_ld,
  input  logic i_prio,
  output logic o_gnt_cpu,
  output logic o_gnt_ld,
  output logic o_any
);

  assign o_gnt_cpu = i_req_cpu && (!i_req_ld || i_prio);
  assign o_gnt_ld  = i_req_ld  && (!i_req_cpu || !i_prio);
  assign o_any     = i_req_cpu || i_req_ld;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-port synchronous RAM between the CPU and the
//               loader/debug port. Every access is a fixed 3-cycle transaction
//               IDLE (grant) -> ACCESS (RAM cycle) -> RESP (ack pulse), with
//               round-robin tie-breaking when both sides request together.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               cpu_cmd/addr/wdata  - CPU request;   cpu_ack/cpu_rdata reply
//               ld_cmd/addr/wdata   - loader request; ld_ack/ld_rdata reply
//               ram_addr/din/write  - RAM command;   ram_dout RAM read data
//               busy_cpu            - CPU holds the grant (ACCESS or RESP)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter bit CPU_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        cpu_cmd,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic [1:0]        ld_cmd,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy_cpu
);

  arb_state_t        r_state;
  arb_state_t        w_next_state;
  logic              r_gnt_cpu;     // 1 = CPU owns the current transaction
  logic              r_write;
  logic              r_contended;   // other side was also requesting at grant
  logic              r_prio;        // 1 = CPU wins the next tie
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_ld_rdata;

  logic w_req_cpu;
  logic w_req_ld;
  logic w_gnt_cpu;
  logic w_gnt_ld;
  logic w_any;

  assign w_req_cpu = cmd_active(cpu_cmd);
  assign w_req_ld  = cmd_active(ld_cmd);

  rr_pick u_rr_pick (
    .i_req_cpu (w_req_cpu),
    .i_req_ld  (w_req_ld),
    .i_prio    (r_prio),
    .o_gnt_cpu (w_gnt_cpu),
    .o_gnt_ld  (w_gnt_ld),
    .o_any     (w_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ARB_IDLE:   if (w_any) w_next_state = ARB_ACCESS;
      ARB_ACCESS: w_next_state = ARB_RESP;
      ARB_RESP:   w_next_state = ARB_IDLE;
      default:    w_next_state = ARB_IDLE;
    endcase
  end

  // Transaction latches, read-data holding registers and the priority pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt_cpu   <= 1'b0;
      r_write     <= 1'b0;
      r_contended <= 1'b0;
      r_prio      <= CPU_FIRST;
      r_addr      <= '0;
      r_din       <= '0;
      r_cpu_rdata <= '0;
      r_ld_rdata  <= '0;
    end else begin
      unique case (r_state)
        ARB_IDLE: begin
          r_contended <= w_req_cpu && w_req_ld;
          if (w_gnt_cpu) begin
            r_gnt_cpu <= 1'b1;
            r_addr    <= cpu_addr;
            r_write   <= (cpu_cmd == MWRITE);
            // ram_din only moves on a write so it otherwise holds its last value.
            if (cpu_cmd == MWRITE) r_din <= cpu_wdata;
          end else if (w_gnt_ld) begin
            r_gnt_cpu <= 1'b0;
            r_addr    <= ld_addr;
            r_write   <= (ld_cmd == MWRITE);
            if (ld_cmd == MWRITE) r_din <= ld_wdata;
          end
        end
        ARB_RESP: begin
          // Capture the read word so rdata holds it between acks.
          if (!r_write) begin
            if (r_gnt_cpu) r_cpu_rdata <= ram_dout;
            else           r_ld_rdata  <= ram_dout;
          end
          // Uncontended grants leave the pointer alone.
          if (r_contended) r_prio <= !r_gnt_cpu;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ram_write = 1'b0;
    cpu_ack   = 1'b0;
    ld_ack    = 1'b0;
    cpu_rdata = r_cpu_rdata;
    ld_rdata  = r_ld_rdata;
    unique case (r_state)
      ARB_ACCESS: ram_write = r_write;
      ARB_RESP: begin
        // RAM data for the ACCESS-cycle address is valid now; forward it
        // straight through so rdata is valid together with the ack.
        if (r_gnt_cpu) begin
          cpu_ack = 1'b1;
          if (!r_write) cpu_rdata = ram_dout;
        end else begin
          ld_ack = 1'b1;
          if (!r_write) ld_rdata = ram_dout;
        end
      end
      default: ;
    endcase
  end

  assign ram_addr = r_addr;
  assign ram_din  = r_din;
  assign busy_cpu = (r_state != ARB_IDLE) && r_gnt_cpu;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter with a behavioural
//               512x16 synchronous RAM attached to the RAM port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cpu_cmd;
  logic [8:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic [1:0]  ld_cmd;
  logic [8:0]  ld_addr;
  logic [15:0] ld_wdata;
  logic        ld_ack;
  logic [15:0] ld_rdata;
  logic [8:0]  ram_addr;
  logic [15:0] ram_din;
  logic        ram_write;
  logic [15:0] ram_dout;
  logic        busy_cpu;

  logic [15:0] mem [0:511];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_cmd   (cpu_cmd),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .ld_cmd    (ld_cmd),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .ld_ack    (ld_ack),
    .ld_rdata  (ld_rdata),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_write (ram_write),
    .ram_dout  (ram_dout),
    .busy_cpu  (busy_cpu)
  );

  // Synchronous RAM: dout valid the cycle after the address is presented.
  always @(posedge clk) begin
    if (ram_write) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One uncontended loader transaction with its ack checked.
  task automatic ld_txn(input logic [1:0] cmd, input logic [8:0] a, input logic [15:0] d);
    ld_cmd = cmd; ld_addr = a; ld_wdata = d;
    tick(); check("ld_txn_addr", 32'(ram_addr), 32'(a));
    tick(); check("ld_txn_ack", 32'(ld_ack), 32'd1);
    ld_cmd = MNONE;
    tick(); check("ld_txn_ack_drop", 32'(ld_ack), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
    reset = 1'b1;
    cpu_cmd = MNONE; cpu_addr = '0; cpu_wdata = '0;
    ld_cmd  = MNONE; ld_addr  = '0; ld_wdata  = '0;

    // Reset then idle
    tick(); tick();
    check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check("rst_ld_ack", 32'(ld_ack), 32'd0);
    check("rst_ram_write", 32'(ram_write), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_din", 32'(ram_din), 32'd0);
    check("rst_busy", 32'(busy_cpu), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_ld_rdata", 32'(ld_rdata), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_acks", 32'({cpu_ack, ld_ack, ram_write, busy_cpu}), 32'd0);
    end

    // Loader write 005 <= ABCD
    ld_cmd = MWRITE; ld_addr = 9'h005; ld_wdata = 16'hABCD;
    tick();
    check("ldw_ram_write", 32'(ram_write), 32'd1);
    check("ldw_ram_addr", 32'(ram_addr), 32'h005);
    check("ldw_ram_din", 32'(ram_din), 32'hABCD);
    check("ldw_ack_early", 32'(ld_ack), 32'd0);
    tick();
    check("ldw_ack", 32'(ld_ack), 32'd1);
    check("ldw_write_off", 32'(ram_write), 32'd0);
    check("ldw_cpu_ack", 32'(cpu_ack), 32'd0);
    ld_cmd = MNONE;
    tick();
    check("ldw_ack_pulse", 32'(ld_ack), 32'd0);

    // CPU read 005
    cpu_cmd = MREAD; cpu_addr = 9'h005;
    tick();
    check("cpur_busy", 32'(busy_cpu), 32'd1);
    check("cpur_addr", 32'(ram_addr), 32'h005);
    check("cpur_no_write", 32'(ram_write), 32'd0);
    tick();
    check("cpur_ack", 32'(cpu_ack), 32'd1);
    check("cpur_rdata", 32'(cpu_rdata), 32'hABCD);
    cpu_cmd = MNONE;
    tick();
    check("cpur_ack_pulse", 32'(cpu_ack), 32'd0);
    check("cpur_rdata_hold", 32'(cpu_rdata), 32'hABCD);
    check("cpur_busy_off", 32'(busy_cpu), 32'd0);

    // Preload 010/020 via two uncontended loader writes
    ld_txn(MWRITE, 9'h010, 16'h1111);
    ld_txn(MWRITE, 9'h020, 16'h2222);

    // Contention: both read continuously for 12 cycles -> C, L, C, L
    cpu_cmd = MREAD; cpu_addr = 9'h010;
    ld_cmd  = MREAD; ld_addr  = 9'h020;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check("cont_cpu_ack", 32'(cpu_ack), 32'((i == 2) || (i == 8)));
      check("cont_ld_ack", 32'(ld_ack), 32'((i == 5) || (i == 11)));
      if (i == 2) check("cont_cpu_rdata", 32'(cpu_rdata), 32'h1111);
      if (i == 5) check("cont_ld_rdata", 32'(ld_rdata), 32'h2222);
    end
    cpu_cmd = MNONE; ld_cmd = MNONE;
    tick();

    // Priority hold: two loader-only reads, then both -> CPU first
    ld_txn(MREAD, 9'h020, 16'h0000);
    ld_txn(MREAD, 9'h010, 16'h0000);
    check("hold_ld_rdata", 32'(ld_rdata), 32'h1111);
    cpu_cmd = MREAD; cpu_addr = 9'h010;
    ld_cmd  = MREAD; ld_addr  = 9'h020;
    tick();
    check("hold_cpu_first", 32'(busy_cpu), 32'd1);
    tick();
    check("hold_cpu_ack", 32'(cpu_ack), 32'd1);
    check("hold_ld_ack", 32'(ld_ack), 32'd0);
    cpu_cmd = MNONE;
    tick(); tick();
    check("hold_ld_addr", 32'(ram_addr), 32'h020);
    tick();
    check("hold_ld_ack2", 32'(ld_ack), 32'd1);
    ld_cmd = MNONE;
    tick();

    // Reset during ACCESS of a CPU write to 1FF (prio now points at loader)
    cpu_cmd = MWRITE; cpu_addr = 9'h1FF; cpu_wdata = 16'h5A5A;
    tick();
    check("mid_write", 32'(ram_write), 32'd1);
    check("mid_addr", 32'(ram_addr), 32'h1FF);
    reset = 1'b1; cpu_cmd = MNONE;
    tick();
    check("mid_rst_ack", 32'(cpu_ack), 32'd0);
    check("mid_rst_write", 32'(ram_write), 32'd0);
    check("mid_rst_busy", 32'(busy_cpu), 32'd0);
    check("mid_rst_addr", 32'(ram_addr), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_quiet", 32'({cpu_ack, ld_ack, ram_write}), 32'd0);
    end
    // Reset must have reloaded prio to CPU
    cpu_cmd = MREAD; cpu_addr = 9'h010;
    ld_cmd  = MREAD; ld_addr  = 9'h020;
    tick();
    check("rst_prio_cpu", 32'(busy_cpu), 32'd1);
    tick();
    check("rst_prio_ack", 32'(cpu_ack), 32'd1);
    check("rst_prio_rdata", 32'(cpu_rdata), 32'h1111);
    cpu_cmd = MNONE;
    tick(); tick(); tick();
    check("rst_prio_ld_ack", 32'(ld_ack), 32'd1);
    check("rst_prio_ld_rdata", 32'(ld_rdata), 32'h2222);
    ld_cmd = MNONE;
    tick();

    // Dropped request still completes
    cpu_cmd = MREAD; cpu_addr = 9'h020;
    tick();
    cpu_cmd = MNONE;
    tick();
    check("drop_ack", 32'(cpu_ack), 32'd1);
    check("drop_rdata", 32'(cpu_rdata), 32'h2222);
    tick();
    check("drop_ack_pulse", 32'(cpu_ack), 32'd0);

    // Command 11 is never granted
    cpu_cmd = 2'b11; ld_cmd = 2'b11;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("illegal_quiet", 32'({cpu_ack, ld_ack, ram_write, busy_cpu}), 32'd0);
      check("illegal_addr", 32'(ram_addr), 32'h020);
    end
    cpu_cmd = MNONE; ld_cmd = MNONE;

    // CPU write leaves cpu_rdata untouched
    cpu_cmd = MWRITE; cpu_addr = 9'h030; cpu_wdata = 16'h3333;
    tick();
    check("cpuw_din", 32'(ram_din), 32'h3333);
    tick();
    check("cpuw_ack", 32'(cpu_ack), 32'd1);
    check("cpuw_rdata_hold", 32'(cpu_rdata), 32'h2222);
    cpu_cmd = MNONE;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
